// File: rtl/dat_mem_pkg.sv
// Shared types and constants for the 8x256 data memory and its two-port arbiter.
package dat_mem_pkg;
  localparam int DW        = 8;
  localparam int AW        = 8;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef logic port_id_t;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the port that was not granted last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);
  always_comb begin
    pick = 2'b00;
    if (req == 2'b11) pick = last ? 2'b01 : 2'b10;
    else if (req[0])  pick = 2'b01;
    else if (req[1])  pick = 2'b10;
  end
endmodule

// File: rtl/dat_mem_arb.sv
// Round-robin arbiter with bounded burst lock for the shared data memory.
// Optional saturating grant/stall counters when DAT_MEM_ARB_STATS_EN is defined.
module dat_mem_arb #(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [1:0]    lock,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [1:0]    rvalid,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
`ifdef DAT_MEM_ARB_STATS_EN
  output logic [15:0]   gnt_cnt0,
  output logic [15:0]   gnt_cnt1,
  output logic [15:0]   stall_cnt,
`endif
  output logic [1:0]    dbg_state,
  output logic [3:0]    dbg_beat_cnt
);
  import dat_mem_pkg::*;

  localparam logic [3:0] BURST   = 4'(MAX_BURST);
  localparam bit         LOCK_EN = (MAX_BURST > 1);

  arb_state_t state, state_next;
  port_id_t   last_gnt, last_next;
  logic [3:0] beat_cnt, beat_next;
  logic [1:0] pick;
  logic       hold0, hold1;

  rr_pick2 u_pick (.req(req), .last(last_gnt), .pick(pick));

  // A lock keeps ownership only while its owner still requests with lock high.
  assign hold0 = (state == LOCK0) && req[0] && lock[0] && (beat_cnt < BURST);
  assign hold1 = (state == LOCK1) && req[1] && lock[1] && (beat_cnt < BURST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      beat_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      last_gnt <= last_next;
      beat_cnt <= beat_next;
    end
  end

  always_comb begin
    state_next = state;
    last_next  = last_gnt;
    beat_next  = beat_cnt;
    gnt        = 2'b00;
    if (reset) begin
      state_next = IDLE;
    end else if (hold0 || hold1) begin
      gnt = hold1 ? 2'b10 : 2'b01;
      if (beat_cnt + 4'd1 >= BURST) begin
        state_next = IDLE;
        beat_next  = 4'd0;
      end else begin
        beat_next  = beat_cnt + 4'd1;
      end
    end else begin
      // IDLE, or a lock released this cycle: last_gnt already names the owner.
      state_next = IDLE;
      beat_next  = 4'd0;
      gnt        = pick;
      if (pick != 2'b00) begin
        last_next = pick[1];
        if (LOCK_EN && lock[pick[1]]) begin
          state_next = pick[1] ? LOCK1 : LOCK0;
          beat_next  = 4'd1;
        end
      end
    end
  end

  always_comb begin
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    if (gnt[0]) begin
      mem_addr  = addr0;
      mem_din   = wdata0;
      mem_wr_en = we[0];
      mem_rd_en = ~we[0];
    end else if (gnt[1]) begin
      mem_addr  = addr1;
      mem_din   = wdata1;
      mem_wr_en = we[1];
      mem_rd_en = ~we[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
      rvalid <= 2'b00;
    end else begin
      rvalid <= gnt & ~we;
      if (gnt[0] && !we[0]) rdata0 <= mem_dout;
      if (gnt[1] && !we[1]) rdata1 <= mem_dout;
    end
  end

`ifdef DAT_MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt0  <= '0;
      gnt_cnt1  <= '0;
      stall_cnt <= '0;
    end else begin
      if (gnt[0] && gnt_cnt0 != 16'hFFFF) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (gnt[1] && gnt_cnt1 != 16'hFFFF) gnt_cnt1 <= gnt_cnt1 + 16'd1;
      if (|(req & ~gnt) && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  assign dbg_state    = state;
  assign dbg_beat_cnt = beat_cnt;
endmodule
